// File: rtl/chanlink_frame_rx.sv
// Receive-side decoder for the DCFEB channel-link frame stream: aligns to
// 100-word frames, recovers ADC words, checks CRC/trailer/serial bits, counts frames and errors.
module chanlink_frame_rx #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [15:0]      DIN,
  input  logic             DVALID,
  input  logic             LAST_WRD,
  input  logic [6:0]       SAMP_MAX,
  output logic [11:0]      ADC_DATA,
  output logic             ADC_VLD,
  output logic [6:0]       ADC_IDX,
  output logic             ADC_OVRLP,
  output logic [6:0]       SAMPLE,
  output logic             FRM_DONE,
  output logic             CRC_ERR,
  output logic             TRLR_ERR,
  output logic             FMT_ERR,
  output logic             SER_ERR,
  output logic             EVT_ERR,
  output logic [5:0]       L1A_NUM,
  output logic [4:0]       L1ABUF,
  output logic             WARN,
  output logic             L1A_PHS,
  output logic             SAMP16,
  output logic             LOCKED,
  output logic [CNT_W-1:0] FRM_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam logic [0:0] ST_HUNT  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  logic [0:0]  state;
  logic [6:0]  wc;
  logic [14:0] crc;
  logic        crc_acc, trl_acc, fmt_acc, ser_acc, phs_acc, s16_acc, warn_acc;
  logic [5:0]  l1a_acc;
  logic [4:0]  buf_acc;

  logic        first, is_data, in_phs, in_s16;
  logic        fmt_bad, ser_bad, crc_bad, trl_bad, trl_f, evt_f, any_err;
  logic [14:0] crc_upd;
  logic [6:0]  samp_nx;

  function automatic logic [14:0] crc15_next(input logic [12:0] d, input logic [14:0] c);
    logic [14:0] n;
    n = '0;
    n[0] = d[0] ^ c[2];
    for (int i = 1; i <= 12; i++) n[i] = d[i-1] ^ d[i] ^ c[i+1] ^ c[i+2];
    n[13] = d[12] ^ c[14] ^ c[0];
    n[14] = c[1];
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Per-word checks; accumulators restart on word 0 so status covers exactly one frame
  always_comb begin
    first   = (wc == 7'd0);
    is_data = (wc < 7'd96);
    in_phs  = (wc >= 7'd73) && (wc <= 7'd77);
    in_s16  = (wc >= 7'd91) && (wc <= 7'd95);
    crc_upd = crc15_next({1'b0, DIN[11:0]}, first ? 15'd0 : crc);
    fmt_bad = is_data && (DIN[15] || DIN[12]);
    ser_bad = 1'b0;
    if (in_phs)                                            ser_bad = (DIN[13] != phs_acc);
    else if (in_s16)                                       ser_bad = (DIN[13] != s16_acc);
    else if (is_data && (wc != 7'd72) && (wc != 7'd90))    ser_bad = DIN[13];
    crc_bad = (wc == 7'd96) && (DIN[15] || (DIN[14:0] != crc));
    trl_bad = ((wc == 7'd97) && (DIN != 16'h700C)) ||
              ((wc == 7'd98) && (DIN[15:12] != 4'h7)) ||
              ((wc == 7'd99) && (DIN != 16'h7FFF));
    trl_f   = trl_acc || trl_bad;
    evt_f   = 1'b0;
    samp_nx = SAMPLE + 7'd1;
    if (LAST_WRD) begin
      evt_f   = (SAMPLE != SAMP_MAX);
      samp_nx = 7'd0;
    end else if (SAMPLE >= SAMP_MAX) begin
      evt_f   = 1'b1;
      samp_nx = 7'd0;
    end
    any_err = crc_acc || trl_f || fmt_acc || ser_acc || evt_f;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_HUNT;
      wc        <= 7'd0;
      crc       <= 15'd0;
      crc_acc   <= 1'b0;
      trl_acc   <= 1'b0;
      fmt_acc   <= 1'b0;
      ser_acc   <= 1'b0;
      phs_acc   <= 1'b0;
      s16_acc   <= 1'b0;
      warn_acc  <= 1'b0;
      l1a_acc   <= 6'd0;
      buf_acc   <= 5'd0;
      ADC_DATA  <= 12'd0;
      ADC_VLD   <= 1'b0;
      ADC_IDX   <= 7'd0;
      ADC_OVRLP <= 1'b0;
      SAMPLE    <= 7'd0;
      FRM_DONE  <= 1'b0;
      CRC_ERR   <= 1'b0;
      TRLR_ERR  <= 1'b0;
      FMT_ERR   <= 1'b0;
      SER_ERR   <= 1'b0;
      EVT_ERR   <= 1'b0;
      L1A_NUM   <= 6'd0;
      L1ABUF    <= 5'd0;
      WARN      <= 1'b0;
      L1A_PHS   <= 1'b0;
      SAMP16    <= 1'b0;
      LOCKED    <= 1'b0;
      FRM_CNT   <= '0;
      ERR_CNT   <= '0;
    end else begin
      ADC_VLD  <= 1'b0;
      FRM_DONE <= 1'b0;
      if (state == ST_HUNT) begin
        if (DVALID && (DIN == 16'h7FFF)) begin
          state  <= ST_FRAME;
          wc     <= 7'd0;
          LOCKED <= 1'b1;
        end
      end else if (DVALID) begin
        wc      <= (wc == 7'd99) ? 7'd0 : wc + 7'd1;
        crc_acc <= (!first && crc_acc) || crc_bad;
        trl_acc <= (!first && trl_acc) || trl_bad;
        fmt_acc <= (!first && fmt_acc) || fmt_bad;
        ser_acc <= (!first && ser_acc) || ser_bad;
        if (is_data) begin
          ADC_VLD   <= 1'b1;
          ADC_DATA  <= DIN[11:0];
          ADC_IDX   <= wc;
          ADC_OVRLP <= ~DIN[14];
          crc       <= crc_upd;
        end
        if (wc == 7'd72) phs_acc <= DIN[13];
        if (wc == 7'd90) s16_acc <= DIN[13];
        if (wc == 7'd98) begin
          l1a_acc  <= DIN[11:6];
          buf_acc  <= DIN[5:1];
          warn_acc <= DIN[0];
        end
        // Word 99: publish the frame result; a bad closing word means alignment is lost
        if (wc == 7'd99) begin
          FRM_DONE <= 1'b1;
          CRC_ERR  <= crc_acc;
          TRLR_ERR <= trl_f;
          FMT_ERR  <= fmt_acc;
          SER_ERR  <= ser_acc;
          EVT_ERR  <= evt_f;
          L1A_NUM  <= l1a_acc;
          L1ABUF   <= buf_acc;
          WARN     <= warn_acc;
          L1A_PHS  <= phs_acc;
          SAMP16   <= s16_acc;
          SAMPLE   <= samp_nx;
          FRM_CNT  <= sat_inc(FRM_CNT);
          if (any_err) ERR_CNT <= sat_inc(ERR_CNT);
          if (DIN != 16'h7FFF) begin
            state  <= ST_HUNT;
            LOCKED <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_chanlink_frame_rx.sv
// Randomized bench for chanlink_frame_rx against a frame-level reference model.
module tb_chanlink_frame_rx;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [15:0]      DIN;
  logic             DVALID, LAST_WRD;
  logic [6:0]       SAMP_MAX;
  logic [11:0]      ADC_DATA;
  logic             ADC_VLD, ADC_OVRLP, FRM_DONE;
  logic [6:0]       ADC_IDX, SAMPLE;
  logic             CRC_ERR, TRLR_ERR, FMT_ERR, SER_ERR, EVT_ERR;
  logic [5:0]       L1A_NUM;
  logic [4:0]       L1ABUF;
  logic             WARN, L1A_PHS, SAMP16, LOCKED;
  logic [CNT_W-1:0] FRM_CNT, ERR_CNT;

  chanlink_frame_rx #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .DVALID(DVALID), .LAST_WRD(LAST_WRD),
    .SAMP_MAX(SAMP_MAX), .ADC_DATA(ADC_DATA), .ADC_VLD(ADC_VLD), .ADC_IDX(ADC_IDX),
    .ADC_OVRLP(ADC_OVRLP), .SAMPLE(SAMPLE), .FRM_DONE(FRM_DONE), .CRC_ERR(CRC_ERR),
    .TRLR_ERR(TRLR_ERR), .FMT_ERR(FMT_ERR), .SER_ERR(SER_ERR), .EVT_ERR(EVT_ERR),
    .L1A_NUM(L1A_NUM), .L1ABUF(L1ABUF), .WARN(WARN), .L1A_PHS(L1A_PHS),
    .SAMP16(SAMP16), .LOCKED(LOCKED), .FRM_CNT(FRM_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic crc, trl, fmt, ser, evt;
    logic [5:0] l1a;
    logic [4:0] bf;
    logic warn, phs, s16;
    logic [6:0] samp;
    logic [CNT_W-1:0] fc, ec;
  } frm_t;
  typedef struct packed {
    logic [6:0]  idx;
    logic [11:0] data;
    logic        ovr;
  } adc_t;

  frm_t adc_dummy_unused;
  frm_t frm_q[$];
  adc_t adc_q[$];
  int checks = 0;
  int failures = 0;

  bit          m_locked;
  int          m_wc, m_samp, m_fc, m_ec;
  logic [15:0] m_words[100];
  logic [15:0] fw[100];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] crc_step(input logic [12:0] d, input logic [14:0] c);
    logic [12:0] dd;
    logic [14:0] cc, n;
    dd = d ^ {d[11:0], 1'b0};
    cc = (c >> 1) ^ (c >> 2);
    n = '0;
    n[12:1] = dd[12:1] ^ cc[12:1];
    n[0]  = d[0] ^ c[2];
    n[13] = d[12] ^ c[14] ^ c[0];
    n[14] = c[1];
    return n;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_wc = 0; m_samp = 0; m_fc = 0; m_ec = 0;
    adc_q.delete(); frm_q.delete();
  endtask

  task automatic model_frame(input logic lw);
    frm_t r;
    logic [14:0] c;
    logic sb;
    int nxt;
    r = '0;
    c = '0;
    for (int i = 0; i < 96; i++) begin
      c = crc_step({1'b0, m_words[i][11:0]}, c);
      if (m_words[i][15] || m_words[i][12]) r.fmt = 1'b1;
      sb = m_words[i][13];
      if (i >= 72 && i <= 77) begin
        if (sb != m_words[72][13]) r.ser = 1'b1;
      end else if (i >= 90 && i <= 95) begin
        if (sb != m_words[90][13]) r.ser = 1'b1;
      end else if (sb) r.ser = 1'b1;
    end
    r.crc  = m_words[96][15] || (m_words[96][14:0] != c);
    r.trl  = (m_words[97] != 16'h700C) || (m_words[98][15:12] != 4'h7) || (m_words[99] != 16'h7FFF);
    r.l1a  = m_words[98][11:6];
    r.bf   = m_words[98][5:1];
    r.warn = m_words[98][0];
    r.phs  = m_words[72][13];
    r.s16  = m_words[90][13];
    nxt = m_samp + 1;
    if (lw) begin
      r.evt = (m_samp != int'(SAMP_MAX));
      m_samp = 0;
    end else if (nxt > int'(SAMP_MAX)) begin
      r.evt = 1'b1;
      m_samp = 0;
    end else m_samp = nxt;
    r.samp = 7'(m_samp);
    if (m_fc < CMAX) m_fc++;
    if ((r.crc || r.trl || r.fmt || r.ser || r.evt) && m_ec < CMAX) m_ec++;
    r.fc = m_fc[CNT_W-1:0];
    r.ec = m_ec[CNT_W-1:0];
    frm_q.push_back(r);
  endtask

  task automatic model_word(input logic [15:0] w, input logic lw);
    adc_t a;
    if (!m_locked) begin
      if (w == 16'h7FFF) begin m_locked = 1'b1; m_wc = 0; end
    end else begin
      m_words[m_wc] = w;
      if (m_wc < 96) begin
        a.idx = 7'(m_wc); a.data = w[11:0]; a.ovr = ~w[14];
        adc_q.push_back(a);
      end
      if (m_wc == 99) begin
        model_frame(lw);
        if (w != 16'h7FFF) m_locked = 1'b0;
        m_wc = 0;
      end else m_wc++;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic lw, input int gap_pct);
    int g;
    g = 0;
    while (g < 4 && int'($urandom_range(0, 99)) < gap_pct) begin
      @(negedge CLK); DVALID = 1'b0; DIN = 16'($urandom); LAST_WRD = 1'($urandom); g++;
    end
    @(negedge CLK); DIN = w; DVALID = 1'b1; LAST_WRD = lw;
    model_word(w, lw);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge CLK); DVALID = 1'b0; LAST_WRD = 1'b0; end
  endtask

  task automatic build_frame(input logic [5:0] l1a, input logic [4:0] bf, input logic w,
                             input logic phs, input logic s16, input bit rnd);
    logic [11:0] d;
    logic b14, sb;
    logic [14:0] c;
    c = '0;
    for (int i = 0; i < 96; i++) begin
      d   = rnd ? 12'($urandom) : 12'(i);
      b14 = rnd ? 1'($urandom) : 1'b0;
      sb  = (i >= 72 && i <= 77) ? phs : (i >= 90 && i <= 95) ? s16 : 1'b0;
      fw[i] = {1'b0, b14, sb, 1'b0, d};
      c = crc_step({1'b0, d}, c);
    end
    fw[96] = {1'b0, c};
    fw[97] = 16'h700C;
    fw[98] = {4'h7, l1a, bf, w};
    fw[99] = 16'h7FFF;
  endtask

  task automatic send_frame(input logic lw, input int gap_pct);
    for (int i = 0; i < 100; i++) send_word(fw[i], (i == 99) ? lw : 1'b0, gap_pct);
  endtask

  task automatic do_reset();
    RST_N = 1'b0; DVALID = 1'b0; DIN = 16'h0; LAST_WRD = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_locked"}, LOCKED, 1'b0);
    check_val({tag, "_adc_vld"}, ADC_VLD, 1'b0);
    check_val({tag, "_frm_done"}, FRM_DONE, 1'b0);
    check_val({tag, "_status"}, {CRC_ERR, TRLR_ERR, FMT_ERR, SER_ERR, EVT_ERR}, 5'd0);
    check_val({tag, "_fields"}, {L1A_NUM, L1ABUF, WARN, L1A_PHS, SAMP16}, 14'd0);
    check_val({tag, "_adc"}, {ADC_DATA, ADC_IDX, ADC_OVRLP}, 20'd0);
    check_val({tag, "_sample"}, SAMPLE, 7'd0);
    check_val({tag, "_cnts"}, {FRM_CNT, ERR_CNT}, '0);
  endtask

  initial begin
    adc_t a;
    frm_t r;
    forever begin
      @(posedge CLK); #1;
      check_val("locked", LOCKED, m_locked);
      if (ADC_VLD) begin
        if (adc_q.size() == 0) check_val("adc_unexpected", 1, 0);
        else begin
          a = adc_q.pop_front();
          check_val("adc_idx", ADC_IDX, a.idx);
          check_val("adc_data", ADC_DATA, a.data);
          check_val("adc_ovrlp", ADC_OVRLP, a.ovr);
        end
      end
      if (FRM_DONE) begin
        if (frm_q.size() == 0) check_val("frm_unexpected", 1, 0);
        else begin
          r = frm_q.pop_front();
          check_val("crc_err", CRC_ERR, r.crc);
          check_val("trlr_err", TRLR_ERR, r.trl);
          check_val("fmt_err", FMT_ERR, r.fmt);
          check_val("ser_err", SER_ERR, r.ser);
          check_val("evt_err", EVT_ERR, r.evt);
          check_val("l1a_num", L1A_NUM, r.l1a);
          check_val("l1abuf", L1ABUF, r.bf);
          check_val("warn", WARN, r.warn);
          check_val("l1a_phs", L1A_PHS, r.phs);
          check_val("samp16", SAMP16, r.s16);
          check_val("sample", SAMPLE, r.samp);
          check_val("frm_cnt", FRM_CNT, r.fc);
          check_val("err_cnt", ERR_CNT, r.ec);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int j, b;
    RST_N = 1'b0; DIN = 16'h0; DVALID = 1'b0; LAST_WRD = 1'b0; SAMP_MAX = 7'd127;
    model_reset();
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    RST_N = 1'b1;

    // good frame
    send_word(16'h7FFF, 1'b0, 0);
    build_frame(6'd5, 5'd3, 1'b1, 1'b0, 1'b0, 0);
    send_frame(1'b0, 0);
    idle(3);
    check_val("t1_frm_cnt", FRM_CNT, 4'd1);
    check_val("t1_fields", {L1A_NUM, L1ABUF, WARN}, {6'd5, 5'd3, 1'b1});
    check_val("t1_adc_left", adc_q.size(), 0);

    // single data bit flipped
    build_frame(6'd5, 5'd3, 1'b1, 1'b0, 1'b0, 0);
    fw[10][3] = ~fw[10][3];
    send_frame(1'b0, 0);
    idle(3);
    check_val("t2_crc_err", CRC_ERR, 1'b1);
    check_val("t2_err_cnt", ERR_CNT, 4'd1);
    check_val("t2_locked", LOCKED, 1'b1);

    // bad closing word: lose lock, ignore one frame, relock at its 7FFF
    build_frame(6'd5, 5'd3, 1'b1, 1'b0, 1'b0, 0);
    fw[99] = 16'h7FFE;
    send_frame(1'b0, 0);
    idle(3);
    check_val("t3_trlr_err", TRLR_ERR, 1'b1);
    check_val("t3_locked", LOCKED, 1'b0);
    build_frame(6'd9, 5'd1, 1'b0, 1'b0, 1'b0, 0);
    send_frame(1'b0, 0);
    idle(3);
    check_val("t3_relock", LOCKED, 1'b1);
    check_val("t3_frm_cnt_hold", FRM_CNT, 4'd3);
    build_frame(6'd9, 5'd1, 1'b0, 1'b0, 1'b0, 0);
    send_frame(1'b0, 0);
    idle(3);
    check_val("t3_frm_cnt", FRM_CNT, 4'd4);

    // event of 16 samples, then a short event; counter saturates along the way
    do_reset();
    SAMP_MAX = 7'd15;
    send_word(16'h7FFF, 1'b0, 0);
    for (int f = 0; f < 16; f++) begin
      build_frame(6'(f), 5'(f), 1'b0, 1'b1, 1'b1, 0);
      send_frame(f == 15, 0);
    end
    idle(3);
    check_val("t4_sample", SAMPLE, 7'd0);
    check_val("t4_serial", {L1A_PHS, SAMP16}, 2'b11);
    check_val("t4_frm_sat", FRM_CNT, 4'hF);
    check_val("t4_err_cnt", ERR_CNT, 4'd0);
    for (int f = 0; f < 15; f++) begin
      build_frame(6'(f), 5'(f), 1'b1, 1'b1, 1'b1, 0);
      send_frame(f == 14, 0);
    end
    idle(3);
    check_val("t4_evt_err", EVT_ERR, 1'b1);
    check_val("t4_sample2", SAMPLE, 7'd0);
    check_val("t4_err_cnt2", ERR_CNT, 4'd1);

    // same random frame without and with gaps, then one stray serial bit
    do_reset();
    SAMP_MAX = 7'd127;
    send_word(16'h7FFF, 1'b0, 0);
    build_frame(6'($urandom), 5'($urandom), 1'($urandom), 1'b1, 1'b0, 1);
    send_frame(1'b0, 0);
    send_frame(1'b0, 40);
    build_frame(6'd17, 5'd22, 1'b0, 1'b1, 1'b0, 0);
    fw[73][13] = 1'b0;
    send_frame(1'b0, 0);
    idle(3);
    check_val("t5_ser_only", {CRC_ERR, TRLR_ERR, FMT_ERR, SER_ERR, EVT_ERR}, 5'b00010);
    check_val("t5_phs", L1A_PHS, 1'b1);

    // randomized frames with assorted faults
    SAMP_MAX = 7'd3;
    for (int k = 0; k < 24; k++) begin
      build_frame(6'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
      j = int'($urandom_range(0, 95));
      b = int'($urandom_range(0, 11));
      case ($urandom_range(0, 7))
        0: fw[j][b] = ~fw[j][b];
        1: fw[j][12] = 1'b1;
        2: fw[j][13] = ~fw[j][13];
        3: fw[97][b] = ~fw[97][b];
        4: fw[98][15:12] = 4'($urandom);
        5: fw[99][b] = ~fw[99][b];
        6: fw[96][15] = 1'b1;
        default: ;
      endcase
      send_frame(1'($urandom_range(0, 3) == 0), 20);
    end
    idle(3);
    check_val("t6_adc_left", adc_q.size(), 0);
    check_val("t6_frm_left", frm_q.size(), 0);

    // reset in the middle of a frame
    do_reset();
    SAMP_MAX = 7'd127;
    send_word(16'h7FFF, 1'b0, 0);
    build_frame(6'd3, 5'd4, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i <= 50; i++) send_word(fw[i], 1'b0, 0);
    @(posedge CLK); #2;
    check_val("t7_adc_drained", adc_q.size(), 0);
    RST_N = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("t7");
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 51; i < 100; i++) send_word(fw[i], 1'b0, 0);
    idle(3);
    check_val("t7_no_frame", FRM_CNT, 4'd0);
    check_val("t7_relock", LOCKED, 1'b1);

    idle(5);
    check_val("end_adc_left", adc_q.size(), 0);
    check_val("end_frm_left", frm_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
